bird_control: RTL

Sequencing FSM that drives the 4-bit `control` code into the bird datapath and consumes its `enable` (draw done) and `flying` (motion still possible) feedback. Once per frame tick it runs clear, move, draw and check over the bird sprite. It handles wandering with wall bounce and LFSR jitter, shot-fall and timed escape. It reports the bird's fate to the game-level logic through `bird_done` and `bird_hit`.

---
 rtl/bird_control.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bird_control.sv
// Frame sequencer for the bird sprite: clear, move, draw and check once per tick.
// It also handles wall bounce with LFSR jitter, the fall after a hit, and the timed escape.
module bird_control #(
  parameter int          X_MIN         = 0,
  parameter int          X_MAX         = 156,
  parameter int          Y_MIN         = 0,
  parameter int          Y_MAX         = 96,
  parameter int          ESCAPE_FRAMES = 600,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       tick,
  input  logic       shot,
  input  logic       enable,
  input  logic       flying,
  input  logic [7:0] bird_x,
  input  logic [6:0] bird_y,
  output logic [3:0] control,
  output logic       busy,
  output logic       bird_done,
  output logic       bird_hit
);

  localparam logic [7:0] XMIN_C = 8'(X_MIN);
  localparam logic [7:0] XMAX_C = 8'(X_MAX);
  localparam logic [6:0] YMIN_C = 7'(Y_MIN);
  localparam logic [6:0] YMAX_C = 7'(Y_MAX);
  localparam logic [9:0] ESC_C  = 10'(ESCAPE_FRAMES);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_CLEAR, S_MOVE_X, S_MOVE_Y,
    S_FALL, S_FLEE, S_DRAW, S_CHECK, S_PREHOLD
  } state_t;

  typedef enum logic [1:0] {M_NORMAL, M_SHOT, M_ESCAPE} mode_t;

  state_t     state, state_nxt;
  mode_t      mode;
  logic       dir_x, dir_y, shot_lat;
  logic [9:0] frame_cnt;
  logic [7:0] lfsr;

  function automatic logic [3:0] ctrl_code(input state_t s, input logic dx, input logic dy);
    case (s)
      S_CLEAR:   return 4'd5;
      S_MOVE_X:  return dx ? 4'd2 : 4'd1;
      S_MOVE_Y:  return dy ? 4'd4 : 4'd3;
      S_FALL:    return 4'd7;
      S_FLEE:    return 4'd8;
      S_DRAW:    return 4'd6;
      S_CHECK:   return 4'd9;
      S_PREHOLD: return 4'd11;
      default:   return 4'd0;
    endcase
  endfunction

  // Fibonacci x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRAW;
      S_WAIT:   if (tick) state_nxt = S_CLEAR;
      S_CLEAR:
        if (enable) begin
          case (mode)
            M_NORMAL: state_nxt = S_MOVE_X;
            M_SHOT:   state_nxt = S_FALL;
            default:  state_nxt = S_FLEE;
          endcase
        end
      S_MOVE_X: state_nxt = S_MOVE_Y;
      S_MOVE_Y: state_nxt = S_DRAW;
      S_FALL:   state_nxt = S_DRAW;
      S_FLEE:   state_nxt = S_DRAW;
      S_DRAW:   if (enable) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (mode != M_NORMAL && !flying) ? S_PREHOLD : S_WAIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      control   <= 4'd0;
      busy      <= 1'b0;
      bird_done <= 1'b0;
      bird_hit  <= 1'b0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      mode      <= M_NORMAL;
      shot_lat  <= 1'b0;
      frame_cnt <= 10'd0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_nxt;
      control   <= ctrl_code(state_nxt, dir_x, dir_y);
      busy      <= (state_nxt != S_IDLE);
      bird_done <= (state == S_PREHOLD);
      bird_hit  <= (state == S_PREHOLD) && (mode == M_SHOT);

      if (state == S_IDLE && start) begin
        shot_lat  <= 1'b0;
        frame_cnt <= 10'd0;
        mode      <= M_NORMAL;
      end else if (state != S_IDLE && shot && mode == M_NORMAL) begin
        shot_lat <= 1'b1;
      end

      // A pending shot overrides an escape that falls due in the same CHECK.
      if (state == S_CHECK && mode == M_NORMAL) begin
        if (frame_cnt != ESC_C)
          frame_cnt <= frame_cnt + 10'd1;
        if (shot_lat)
          mode <= M_SHOT;
        else if (frame_cnt + 10'd1 == ESC_C)
          mode <= M_ESCAPE;

        if (bird_x >= XMAX_C)
          dir_x <= 1'b0;
        else if (bird_x <= XMIN_C)
          dir_x <= 1'b1;

        if (bird_y >= YMAX_C)
          dir_y <= 1'b0;
        else if (bird_y <= YMIN_C)
          dir_y <= 1'b1;
        else if (lfsr[2:0] == 3'd0)
          dir_y <= ~dir_y;

        lfsr <= lfsr_step(lfsr);
      end
    end
  end

endmodule
